multicycle_alu: RTL

//  Parametrised, registered ALU with valid/ready handshakes on input and output.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/multicycle_alu_if.sv | 27 ++
 rtl/alu_iter_muldiv.sv | 82 ++++++++
 rtl/multicycle_alu.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type and opcode classification for multicycle_alu.
package alu_pkg;

    localparam int unsigned OP_AND  = 0;
    localparam int unsigned OP_OR   = 1;
    localparam int unsigned OP_ADD  = 2;
    localparam int unsigned OP_SLL  = 3;
    localparam int unsigned OP_SRL  = 4;
    localparam int unsigned OP_SRA  = 5;
    localparam int unsigned OP_SUB  = 6;
    localparam int unsigned OP_SLTU = 7;
    localparam int unsigned OP_MUL  = 8;
    localparam int unsigned OP_DIVU = 9;
    localparam int unsigned OP_REMU = 10;
    localparam int unsigned OP_NOR  = 12;
    localparam int unsigned OP_SLT  = 13;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} alu_state_e;

    function automatic logic is_multicycle(input int unsigned op);
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/multicycle_alu_if.sv
// Operand/result handshake bundle between the register-read stage, the ALU and writeback.
interface multicycle_alu_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned CTRL_W = 4
);
    logic [CTRL_W-1:0] Control;
    logic [WIDTH-1:0]  Input1;
    logic [WIDTH-1:0]  Input2;
    logic              In_valid;
    logic              In_ready;
    logic [WIDTH-1:0]  Out;
    logic              Zero;
    logic              Overflow;
    logic              Illegal;
    logic              Out_valid;
    logic              Out_ready;

    modport master (
        output Control, Input1, Input2, In_valid, Out_ready,
        input  In_ready, Out, Zero, Overflow, Illegal, Out_valid
    );

    modport slave (
        input  Control, Input1, Input2, In_valid, Out_ready,
        output In_ready, Out, Zero, Overflow, Illegal, Out_valid
    );
endinterface

// File: rtl/alu_iter_muldiv.sv
// Iterative MUL (low half) / DIVU / REMU: one shift-add or restoring step per cycle, WIDTH steps.
// Only instantiated when ALU_MULDIV_EN is defined.
module alu_iter_muldiv
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CTRL_W-1:0] op,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    output logic              done,
    output logic [WIDTH-1:0]  result
);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    logic              run_q;
    logic              done_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CTRL_W-1:0] op_q;
    logic [WIDTH-1:0]  x_q;    // multiplicand, or dividend shifting out / quotient shifting in
    logic [WIDTH-1:0]  y_q;    // multiplier, or divisor
    logic [WIDTH-1:0]  acc_q;  // product, or partial remainder

    logic              is_mul;
    logic [WIDTH:0]    trial;
    logic              ge;
    logic [WIDTH-1:0]  diff;

    always_comb begin
        is_mul = (32'(op_q) == OP_MUL);
        trial  = {acc_q, x_q[WIDTH-1]};
        ge     = (trial >= {1'b0, y_q});
        // When ge holds the true difference is below the divisor, so the low bits suffice.
        diff   = trial[WIDTH-1:0] - y_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_q  <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= '0;
            op_q   <= '0;
            x_q    <= '0;
            y_q    <= '0;
            acc_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                run_q <= 1'b1;
                cnt_q <= '0;
                op_q  <= op;
                x_q   <= a;
                y_q   <= b;
                acc_q <= '0;
            end else if (run_q) begin
                if (is_mul) begin
                    if (y_q[0]) begin
                        acc_q <= acc_q + x_q;
                    end
                    x_q <= x_q << 1;
                    y_q <= y_q >> 1;
                end else begin
                    acc_q <= ge ? diff : trial[WIDTH-1:0];
                    x_q   <= {x_q[WIDTH-2:0], ge};
                end
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    run_q  <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign done   = done_q;
    assign result = (32'(op_q) == OP_DIVU) ? x_q : acc_q;

endmodule

// File: rtl/multicycle_alu.sv
// Registered ALU with valid/ready handshakes. Define ALU_MULDIV_EN to build the iterative
// MUL/DIVU/REMU unit; otherwise opcodes 8/9/10 report Illegal at single-cycle latency.
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned CTRL_W = 4
) (
    input  logic              Clock,
    input  logic              Reset_n,
    multicycle_alu_if.slave   alu
);
    localparam int unsigned SH_W = $clog2(WIDTH);

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] out_q;
    logic             zero_q, ovf_q, illegal_q;

    logic [WIDTH-1:0] a, b, sum, diff, sc_res;
    logic [SH_W-1:0]  shamt;
    logic             sc_ovf, sc_ill;
    int unsigned      op;
    logic             accept, start_md;

    assign a      = alu.Input1;
    assign b      = alu.Input2;
    assign op     = 32'(alu.Control);
    assign shamt  = b[SH_W-1:0];
    assign sum    = a + b;
    assign diff   = a - b;
    assign accept = (state_q == IDLE) && alu.In_valid;

`ifdef ALU_MULDIV_EN
    logic             md_done;
    logic [WIDTH-1:0] md_res;

    assign start_md = accept && is_multicycle(op);

    alu_iter_muldiv #(
        .WIDTH  (WIDTH),
        .CTRL_W (CTRL_W)
    ) u_muldiv (
        .clk    (Clock),
        .rst_n  (Reset_n),
        .start  (start_md),
        .op     (alu.Control),
        .a      (a),
        .b      (b),
        .done   (md_done),
        .result (md_res)
    );
`else
    assign start_md = 1'b0;
`endif

    // Single-cycle datapath; anything not decoded here (incl. 8/9/10 without muldiv) is illegal.
    always_comb begin
        sc_res = '0;
        sc_ovf = 1'b0;
        sc_ill = 1'b0;
        case (op)
            OP_AND:  sc_res = a & b;
            OP_OR:   sc_res = a | b;
            OP_NOR:  sc_res = ~(a | b);
            OP_ADD: begin
                sc_res = sum;
                sc_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res = diff;
                sc_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLL:  sc_res = a << shamt;
            OP_SRL:  sc_res = a >> shamt;
            OP_SRA:  sc_res = $signed(a) >>> shamt;
            OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: sc_ill = 1'b1;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (alu.In_valid) begin
                    state_d = start_md ? BUSY : DONE;
                end
            end
            BUSY: begin
`ifdef ALU_MULDIV_EN
                if (md_done) begin
                    state_d = DONE;
                end
`else
                state_d = IDLE;
`endif
            end
            DONE: begin
                if (alu.Out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            out_q     <= '0;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
            illegal_q <= 1'b0;
        end else if (accept && !start_md) begin
            out_q     <= sc_res;
            zero_q    <= (sc_res == '0);
            ovf_q     <= sc_ovf;
            illegal_q <= sc_ill;
`ifdef ALU_MULDIV_EN
        end else if ((state_q == BUSY) && md_done) begin
            out_q     <= md_res;
            zero_q    <= (md_res == '0);
            ovf_q     <= 1'b0;
            illegal_q <= 1'b0;
`endif
        end
    end

    always_comb begin
        alu.In_ready  = (state_q == IDLE);
        alu.Out_valid = (state_q == DONE);
        alu.Out       = out_q;
        alu.Zero      = zero_q;
        alu.Overflow  = ovf_q;
        alu.Illegal   = illegal_q;
    end

endmodule
